// File: rtl/trellis_io_bank.sv
// trellis_io_bank: registered multi-bit bidirectional pad bank.
// Fabric data is registered before it reaches the pads. A bank-wide direction
// FSM inserts a programmable Hi-Z gap before the bank starts driving, and
// releases the pads immediately. Pad values come back through a synchroniser
// and a per-bit glitch filter that also emits a one-cycle change pulse.
module trellis_io_bank #(
    parameter int    WIDTH  = 8,
    parameter string MODE   = "BIDIR",
    parameter int    SYNC   = 2,
    parameter int    FILTER = 1,
    parameter int    TURN   = 1
) (
    input  logic             CLK,
    input  logic             LSR,
    inout  wire  [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] I,
    input  logic             T,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] O_EDGE,
    output logic             DRIVING
);

    localparam bit IS_IN  = (MODE == "INPUT");
    localparam bit IS_OUT = (MODE == "OUTPUT");
    localparam logic [3:0] TURN_M1 = 4'((TURN > 0) ? (TURN - 1) : 0);

    // Reject parameter values the hardware cannot represent.
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("trellis_io_bank: WIDTH must be 1..64");
    end
    if (!(MODE == "INPUT" || MODE == "OUTPUT" || MODE == "BIDIR")) begin : g_bad_mode
        $error("trellis_io_bank: MODE must be INPUT, OUTPUT or BIDIR");
    end
    if (SYNC < 0 || SYNC > 3) begin : g_bad_sync
        $error("trellis_io_bank: SYNC must be 0..3");
    end
    if (FILTER < 1 || FILTER > 255) begin : g_bad_filter
        $error("trellis_io_bank: FILTER must be 1..255");
    end
    if (TURN < 0 || TURN > 15) begin : g_bad_turn
        $error("trellis_io_bank: TURN must be 0..15");
    end

    typedef enum logic [1:0] {
        ST_RX  = 2'd0,
        ST_GAP = 2'd1,
        ST_TX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nx;
    logic [WIDTH-1:0] oreg;
    logic             t_rel;
    logic             drive;

    // T is pulled down at the pad: only a solid 1 requests release.
    assign t_rel = (T === 1'b1);

    // Output data register, loaded from fabric every cycle.
    always_ff @(posedge CLK) begin
        if (LSR) begin
            oreg <= '0;
        end else begin
            oreg <= I;
        end
    end

    // Direction FSM state and turnaround counter registers.
    always_ff @(posedge CLK) begin
        if (LSR) begin
            state <= ST_RX;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Direction FSM next state: gap before driving, immediate release.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (IS_IN) begin
            state_nx = ST_RX;
        end else begin
            case (state)
                ST_RX: begin
                    if (!t_rel) begin
                        if (TURN == 0) begin
                            state_nx = ST_TX;
                        end else begin
                            state_nx = ST_GAP;
                            cnt_nx   = TURN_M1;
                        end
                    end
                end
                ST_GAP: begin
                    if (t_rel) begin
                        state_nx = ST_RX;
                    end else if (cnt == 4'd0) begin
                        state_nx = ST_TX;
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
                ST_TX: begin
                    if (t_rel) begin
                        state_nx = ST_RX;
                    end
                end
                default: begin
                    state_nx = ST_RX;
                end
            endcase
        end
    end

    // Pads are decoded only from registered state, never from I or T.
    assign drive   = (state == ST_TX) && !IS_IN;
    assign DRIVING = drive;
    assign B       = drive ? oreg : {WIDTH{1'bz}};

    if (!IS_OUT) begin : g_in_path
        logic [WIDTH-1:0] b_map;
        logic [WIDTH-1:0] samp;
        logic [WIDTH-1:0] o_q;
        logic [WIDTH-1:0] e_q;
        logic [7:0]       fc [WIDTH];

        // Map undriven or unknown pad bits to 0 before sampling.
        always_comb begin
            b_map = '0;
            for (int k = 0; k < WIDTH; k++) begin
                b_map[k] = (B[k] === 1'b1);
            end
        end

        if (SYNC == 0) begin : g_nosync
            assign samp = b_map;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC];

            // Synchroniser chain from the pads into the clock domain.
            always_ff @(posedge CLK) begin
                if (LSR) begin
                    for (int k = 0; k < SYNC; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= b_map;
                    for (int k = 1; k < SYNC; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign samp = sync_q[SYNC-1];
        end

        // Per-bit glitch filter: FILTER consecutive disagreeing samples flip O.
        always_ff @(posedge CLK) begin
            if (LSR) begin
                o_q <= '0;
                e_q <= '0;
                for (int k = 0; k < WIDTH; k++) begin
                    fc[k] <= 8'd0;
                end
            end else begin
                for (int k = 0; k < WIDTH; k++) begin
                    if (samp[k] == o_q[k]) begin
                        fc[k]  <= 8'd0;
                        e_q[k] <= 1'b0;
                    end else if (({1'b0, fc[k]} + 9'd1) == 9'(FILTER)) begin
                        o_q[k] <= samp[k];
                        fc[k]  <= 8'd0;
                        e_q[k] <= 1'b1;
                    end else begin
                        fc[k]  <= fc[k] + 8'd1;
                        e_q[k] <= 1'b0;
                    end
                end
            end
        end

        assign O      = o_q;
        assign O_EDGE = e_q;
    end else begin : g_no_in_path
        assign O      = '0;
        assign O_EDGE = '0;
    end

endmodule
